// File: rtl/ofdm_tx_framer.sv
// OFDM transmit framer: emits a programmable preamble followed by cyclic-prefixed
// symbols streamed from a two-entry ping-pong buffer, one sample per cycle.
module ofdm_tx_framer #(
    parameter int SYMBOL_LEN        = 64,
    parameter int CYCLIC_PREFIX_LEN = 16,
    parameter int PREAMBLE_LEN      = 320,
    parameter int MAX_NUM_SYMBOLS   = 512
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [$clog2(MAX_NUM_SYMBOLS+1)-1:0] num_symbols,
    input  logic                                 num_symbols_valid,
    input  logic [$clog2(PREAMBLE_LEN)-1:0]      pre_wr_addr,
    input  logic [31:0]                          pre_wr_data,
    input  logic                                 pre_wr_stb,
    input  logic [31:0]                          i_tdata,
    input  logic                                 i_tlast,
    input  logic                                 i_tvalid,
    output logic                                 i_tready,
    output logic [31:0]                          o_tdata,
    output logic                                 o_tlast,
    output logic                                 o_tvalid,
    input  logic                                 o_tready,
    output logic                                 o_err
);
    localparam int NS_W    = $clog2(MAX_NUM_SYMBOLS+1);
    localparam int PA_W    = $clog2(PREAMBLE_LEN);
    localparam int SL_W    = $clog2(SYMBOL_LEN);
    localparam int FR_LEN  = CYCLIC_PREFIX_LEN + SYMBOL_LEN;
    localparam int FR_W    = $clog2(FR_LEN);
    localparam int Q_DEPTH = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_SYMBOLS} state_t;
    typedef enum logic [1:0] {ISS_NONE, ISS_PRE, ISS_SYM} iss_t;

    state_t            r_state;
    iss_t              r_iss;
    logic [NS_W-1:0]   r_num;
    logic [PA_W-1:0]   r_pre_addr;
    logic [NS_W-1:0]   r_rd_sym;
    logic [FR_W-1:0]   r_rd_idx;
    logic [NS_W-1:0]   r_wr_sym;
    logic [SL_W-1:0]   r_wr_idx;
    logic              r_wr_buf;
    logic              r_in_active;
    logic [1:0]        r_full;
    logic              r_inflight;
    logic              r_inflight_sym;
    logic              r_inflight_last;
    logic              r_inflight_pre_end;
    logic [31:0]       r_pre_rd;
    logic [31:0]       r_sym_rd;
    logic [31:0]       r_q_data    [Q_DEPTH];
    logic              r_q_last    [Q_DEPTH];
    logic              r_q_pre_end [Q_DEPTH];
    logic [1:0]        r_q_cnt;
    logic              r_err;

    logic [31:0]       r_pre_ram [PREAMBLE_LEN];
    logic [31:0]       r_sym_ram [2*SYMBOL_LEN];

    logic              w_start;
    logic              w_pop;
    logic              w_credit;
    logic              w_rd_buf;
    logic              w_iss_pre;
    logic              w_iss_sym;
    logic              w_pre_last;
    logic              w_rd_fr_last;
    logic              w_rd_sym_last;
    logic [SL_W-1:0]   w_rd_off;
    logic [SL_W:0]     w_rd_addr;
    logic              w_release;
    logic              w_accept;
    logic              w_in_last;
    logic              w_wr_done;
    logic [1:0]        w_push_pos;
    logic [31:0]       w_push_data;

    assign w_start = (r_state == ST_IDLE) && num_symbols_valid && (num_symbols != '0)
                     && (num_symbols <= NS_W'(MAX_NUM_SYMBOLS));
    assign w_pop   = (r_q_cnt != 2'd0) && o_tready;

    // Reads are only issued when the output queue is guaranteed room for them.
    assign w_credit = ({1'b0, r_q_cnt} + {2'b0, r_inflight}) < (3'd3 + {2'b0, w_pop});

    assign w_rd_buf      = r_rd_sym[0];
    assign w_pre_last    = (r_pre_addr == PA_W'(PREAMBLE_LEN-1));
    assign w_rd_fr_last  = (r_rd_idx == FR_W'(FR_LEN-1));
    assign w_rd_sym_last = (r_rd_sym == r_num - NS_W'(1));
    assign w_iss_pre     = (w_start || (r_iss == ISS_PRE)) && w_credit;
    assign w_iss_sym     = (r_iss == ISS_SYM) && r_full[w_rd_buf] && w_credit;
    assign w_release     = w_iss_sym && w_rd_fr_last;

    assign w_rd_off  = (r_rd_idx < FR_W'(CYCLIC_PREFIX_LEN))
                       ? r_rd_idx[SL_W-1:0] + SL_W'(SYMBOL_LEN-CYCLIC_PREFIX_LEN)
                       : r_rd_idx[SL_W-1:0] - SL_W'(CYCLIC_PREFIX_LEN);
    assign w_rd_addr = {w_rd_buf, w_rd_off};

    assign i_tready  = r_in_active && !r_full[r_wr_buf];
    assign w_accept  = i_tvalid && i_tready;
    assign w_wr_done = w_accept && (r_wr_idx == SL_W'(SYMBOL_LEN-1));
    assign w_in_last = (r_wr_sym == r_num - NS_W'(1)) && (r_wr_idx == SL_W'(SYMBOL_LEN-1));

    assign w_push_pos  = r_q_cnt - {1'b0, w_pop};
    assign w_push_data = r_inflight_sym ? r_sym_rd : r_pre_rd;

    assign o_tvalid = (r_q_cnt != 2'd0);
    assign o_tdata  = r_q_data[0];
    assign o_tlast  = o_tvalid && r_q_last[0];
    assign o_err    = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= ST_IDLE;
            r_iss              <= ISS_NONE;
            r_num              <= '0;
            r_pre_addr         <= '0;
            r_rd_sym           <= '0;
            r_rd_idx           <= '0;
            r_wr_sym           <= '0;
            r_wr_idx           <= '0;
            r_wr_buf           <= 1'b0;
            r_in_active        <= 1'b0;
            r_full             <= 2'b00;
            r_inflight         <= 1'b0;
            r_inflight_sym     <= 1'b0;
            r_inflight_last    <= 1'b0;
            r_inflight_pre_end <= 1'b0;
            r_q_cnt            <= 2'd0;
            r_err              <= 1'b0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                r_q_data[i]    <= '0;
                r_q_last[i]    <= 1'b0;
                r_q_pre_end[i] <= 1'b0;
            end
        end else begin
            r_err <= w_accept && (i_tlast != w_in_last);

            if (w_start) begin
                r_num       <= num_symbols;
                r_state     <= ST_PREAMBLE;
                r_iss       <= ISS_PRE;
                r_in_active <= 1'b1;
                r_wr_sym    <= '0;
                r_wr_idx    <= '0;
                r_wr_buf    <= 1'b0;
                r_rd_sym    <= '0;
                r_rd_idx    <= '0;
                r_pre_addr  <= '0;
            end

            if (w_iss_pre) begin
                r_pre_addr <= w_pre_last ? '0 : r_pre_addr + PA_W'(1);
                if (w_pre_last)
                    r_iss <= ISS_SYM;
            end

            if (w_iss_sym) begin
                if (w_rd_fr_last) begin
                    r_rd_idx <= '0;
                    r_rd_sym <= r_rd_sym + NS_W'(1);
                    if (w_rd_sym_last)
                        r_iss <= ISS_NONE;
                end else begin
                    r_rd_idx <= r_rd_idx + FR_W'(1);
                end
            end

            r_inflight         <= w_iss_pre || w_iss_sym;
            r_inflight_sym     <= w_iss_sym;
            r_inflight_last    <= w_iss_sym && w_rd_fr_last && w_rd_sym_last;
            r_inflight_pre_end <= w_iss_pre && w_pre_last;

            if (w_accept) begin
                if (w_wr_done) begin
                    r_wr_idx <= '0;
                    r_wr_buf <= ~r_wr_buf;
                    r_wr_sym <= r_wr_sym + NS_W'(1);
                    if (w_in_last)
                        r_in_active <= 1'b0;
                end else begin
                    r_wr_idx <= r_wr_idx + SL_W'(1);
                end
            end

            // A buffer may be filled and the other released in the same cycle.
            for (int b = 0; b < 2; b++) begin
                if (w_wr_done && (r_wr_buf == 1'(b)))
                    r_full[b] <= 1'b1;
                else if (w_release && (w_rd_buf == 1'(b)))
                    r_full[b] <= 1'b0;
            end

            // Head entry is the registered output; entries 1..2 form the skid buffer.
            if (w_pop) begin
                for (int i = 0; i < Q_DEPTH-1; i++) begin
                    r_q_data[i]    <= r_q_data[i+1];
                    r_q_last[i]    <= r_q_last[i+1];
                    r_q_pre_end[i] <= r_q_pre_end[i+1];
                end
            end
            if (r_inflight) begin
                r_q_data[w_push_pos]    <= w_push_data;
                r_q_last[w_push_pos]    <= r_inflight_last;
                r_q_pre_end[w_push_pos] <= r_inflight_pre_end;
            end
            r_q_cnt <= r_q_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

            if (w_pop && r_q_pre_end[0])
                r_state <= ST_SYMBOLS;
            if (w_pop && r_q_last[0])
                r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && pre_wr_stb
            && ({1'b0, pre_wr_addr} < (PA_W+1)'(PREAMBLE_LEN)))
            r_pre_ram[pre_wr_addr] <= pre_wr_data;
        if (w_iss_pre)
            r_pre_rd <= r_pre_ram[r_pre_addr];
        if (w_accept)
            r_sym_ram[{r_wr_buf, r_wr_idx}] <= i_tdata;
        if (w_iss_sym)
            r_sym_rd <= r_sym_ram[w_rd_addr];
    end

endmodule

// File: tb/tb_ofdm_tx_framer.sv
// Directed bench for ofdm_tx_framer: table of bursts checked sample-by-sample
// against a reference sequence, plus reset/idle corner sequences.
module tb_ofdm_tx_framer;
    localparam int SL   = 64;
    localparam int CP   = 16;
    localparam int PL   = 320;
    localparam int MAXN = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  num_symbols;
    logic        num_symbols_valid;
    logic [8:0]  pre_wr_addr;
    logic [31:0] pre_wr_data;
    logic        pre_wr_stb;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        o_err;

    ofdm_tx_framer #(
        .SYMBOL_LEN(SL), .CYCLIC_PREFIX_LEN(CP), .PREAMBLE_LEN(PL), .MAX_NUM_SYMBOLS(MAXN)
    ) dut (
        .clk(clk), .reset(reset),
        .num_symbols(num_symbols), .num_symbols_valid(num_symbols_valid),
        .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data), .pre_wr_stb(pre_wr_stb),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int num;
        bit rand_in;
        bit rand_out;
        bit delay_in;
        int extra_tlast;
        bit drop_last;
        int base;
        bit pre_wr;
        int exp_len;
        int exp_errs;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference burst: preamble value = address, then CP tail + full symbol of a ramp.
    function automatic int exp_out(input int j, input int base);
        int s, t, idx;
        if (j < PL) return j;
        s = (j - PL) / (CP + SL);
        t = (j - PL) % (CP + SL);
        idx = (t < CP) ? (SL - CP + t) : (t - CP);
        return base + s * SL + idx;
    endfunction

    task automatic run_burst(input int id, input vec_t v, input int abort_at);
        int  in_idx = 0, out_idx = 0, c = 0, first_valid = -1, last_cyc = -1, obs_errs = 0;
        int  total_in = v.num * SL;
        int  budget = v.exp_len * 8 + 200;
        bit  err_pend = 0, stalled = 0, in_pend = 0, done = 0;
        logic [31:0] held_d;
        logic        held_l;
        @(negedge clk);
        while (!done) begin
            num_symbols       = 10'(v.num);
            num_symbols_valid = (c == 0);
            pre_wr_stb        = v.pre_wr && (c == 10);
            pre_wr_addr       = 9'd5;
            pre_wr_data       = 32'hDEAD_BEEF;
            o_tready          = v.rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!in_pend) begin
                if (in_idx < total_in && (!v.delay_in || out_idx >= PL)
                    && (!v.rand_in || $urandom_range(0, 1) == 1)) begin
                    i_tvalid = 1'b1;
                    i_tdata  = 32'(v.base + in_idx);
                    i_tlast  = ((in_idx == total_in - 1) && !v.drop_last) || (in_idx == v.extra_tlast);
                end else begin
                    i_tvalid = 1'b0;
                    i_tlast  = 1'b0;
                end
            end
            #1;
            chk("o_err", o_err, err_pend);
            if (o_err) obs_errs++;
            if (stalled) begin
                chk("hold_valid", o_tvalid, 1);
                chk("hold_data", o_tdata, held_d);
                chk("hold_last", o_tlast, held_l);
            end
            if (o_tvalid && first_valid < 0) first_valid = c;
            stalled = 0;
            if (o_tvalid && o_tready) begin
                chk("o_tdata", o_tdata, exp_out(out_idx, v.base));
                chk("o_tlast", o_tlast, out_idx == v.exp_len - 1);
                if (o_tlast) begin
                    last_cyc = c;
                    done = 1;
                end
                out_idx++;
            end else if (o_tvalid) begin
                stalled = 1;
                held_d  = o_tdata;
                held_l  = o_tlast;
            end
            err_pend = 0;
            if (i_tvalid && i_tready) begin
                err_pend = (i_tlast != (in_idx == total_in - 1));
                in_idx++;
                in_pend = 0;
            end else begin
                in_pend = i_tvalid;
            end
            if (abort_at >= 0 && out_idx >= abort_at) begin
                $display("burst %0d: num=%0d aborted after %0d samples", id, v.num, out_idx);
                return;
            end
            if (c > budget) begin
                chk("burst_timeout", c, budget);
                done = 1;
            end
            if (!done) begin
                @(negedge clk);
                c++;
            end
        end
        pre_wr_stb = 1'b0;
        chk("burst_len", out_idx, v.exp_len);
        chk("err_count", obs_errs, v.exp_errs);
        chk("latency", first_valid, 2);
        if (!v.rand_in && !v.rand_out && !v.delay_in)
            chk("no_gaps", last_cyc - first_valid + 1, v.exp_len);
        $display("burst %0d: num=%0d samples=%0d o_err_pulses=%0d cycles=%0d",
                 id, v.num, out_idx, obs_errs, c + 1);
    endtask

    task automatic idle_check(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            num_symbols_valid = 1'b0;
            #1;
            chk({name, "_tvalid"}, o_tvalid, 0);
            chk({name, "_tready"}, i_tready, 0);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{num:2, rand_in:0, rand_out:0, delay_in:0, extra_tlast:-1, drop_last:0,
                    base:32'h0,     pre_wr:1, exp_len:480, exp_errs:0};
        vecs[1] = '{num:5, rand_in:1, rand_out:1, delay_in:0, extra_tlast:-1, drop_last:0,
                    base:32'h10000, pre_wr:0, exp_len:720, exp_errs:0};
        vecs[2] = '{num:2, rand_in:0, rand_out:0, delay_in:1, extra_tlast:-1, drop_last:0,
                    base:32'h20000, pre_wr:0, exp_len:480, exp_errs:0};
        vecs[3] = '{num:1, rand_in:0, rand_out:0, delay_in:0, extra_tlast:10, drop_last:0,
                    base:32'h30000, pre_wr:0, exp_len:400, exp_errs:1};
        vecs[4] = '{num:1, rand_in:0, rand_out:0, delay_in:0, extra_tlast:-1, drop_last:1,
                    base:32'h40000, pre_wr:0, exp_len:400, exp_errs:1};
        vecs[5] = '{num:3, rand_in:0, rand_out:0, delay_in:0, extra_tlast:-1, drop_last:0,
                    base:32'h50000, pre_wr:0, exp_len:560, exp_errs:0};

        reset = 1'b1;
        num_symbols = '0; num_symbols_valid = 1'b0;
        pre_wr_addr = '0; pre_wr_data = '0; pre_wr_stb = 1'b0;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tlast", o_tlast, 0);
        chk("rst_err", o_err, 0);
        chk("rst_tready", i_tready, 0);

        for (int a = 0; a < PL; a++) begin
            @(negedge clk);
            pre_wr_stb = 1'b1; pre_wr_addr = 9'(a); pre_wr_data = 32'(a);
        end
        @(negedge clk);
        pre_wr_stb = 1'b0;

        num_symbols = 10'd0; num_symbols_valid = 1'b1;
        idle_check("zero_num", 6);
        @(negedge clk);
        num_symbols = 10'(MAXN + 1); num_symbols_valid = 1'b1;
        idle_check("over_max", 6);
        $display("idle: num_symbols=0 and %0d ignored", MAXN + 1);

        for (int k = 0; k < 6; k++)
            run_burst(k, vecs[k], -1);

        v = '{num:3, rand_in:0, rand_out:0, delay_in:0, extra_tlast:-1, drop_last:0,
              base:32'h60000, pre_wr:0, exp_len:560, exp_errs:0};
        run_burst(6, v, 350);
        reset = 1'b1; i_tvalid = 1'b0; num_symbols_valid = 1'b0; o_tready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_tvalid", o_tvalid, 0);
        chk("midrst_tlast", o_tlast, 0);
        chk("midrst_tready", i_tready, 0);
        chk("midrst_err", o_err, 0);
        v = '{num:1, rand_in:0, rand_out:0, delay_in:0, extra_tlast:-1, drop_last:0,
              base:32'h70000, pre_wr:0, exp_len:400, exp_errs:0};
        run_burst(7, v, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ofdm_tx_framer.md
Name: ofdm_tx_framer

Overview:
- Transmit-side counterpart of the OFDM receive sync/framer chain.
- Accepts time-domain OFDM symbols from the IFFT and emits a burst of the form: programmable preamble (short plus long training, PREAMBLE_LEN samples), then num_symbols symbols, each with a cyclic prefix prepended.
- Symbols are buffered in a two-entry ping-pong RAM so that streaming runs at one sample per cycle.
- The preamble is held in a RAM that software writes through a settings-style write port.

Parameters:
- SYMBOL_LEN, 64, samples per OFDM symbol (power of 2).
- CYCLIC_PREFIX_LEN, 16, cyclic-prefix samples (1..SYMBOL_LEN-1).
- PREAMBLE_LEN, 320, preamble samples: 160 short plus 160 long.
- MAX_NUM_SYMBOLS, 512, maximum symbols per burst.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- num_symbols  in  $clog2(MAX_NUM_SYMBOLS+1)  symbols in the next burst.
- num_symbols_valid  in  1  one-cycle strobe that starts a burst.
- pre_wr_addr  in  $clog2(PREAMBLE_LEN)  preamble RAM write address.
- pre_wr_data  in  32  preamble sample, {I[31:16],Q[15:0]}.
- pre_wr_stb  in  1  preamble write strobe.
- i_tdata  in  32  IFFT output sample.
- i_tlast  in  1  marks the last sample of the burst's final symbol.
- i_tvalid  in  1  AXI-Stream valid.
- i_tready  out  1  AXI-Stream ready.
- o_tdata  out  32  framed burst sample.
- o_tlast  out  1  marks the last sample of the burst.
- o_tvalid  out  1  AXI-Stream valid.
- o_tready  in  1  AXI-Stream ready.
- o_err  out  1  one-cycle pulse on an i_tlast mismatch.

Behaviour:
- Reset:
  - o_tvalid=0, o_tlast=0, o_err=0, i_tready=0.
  - State is IDLE; both symbol buffers are empty; all counters are 0.
  - Preamble RAM contents are not cleared.
  - Reset in mid-burst abandons the burst immediately; no o_tlast is produced.
- Preamble RAM writes:
  - Applied only in IDLE.
  - Ignored in any other state.
  - Ignored when pre_wr_addr >= PREAMBLE_LEN.
- State machine IDLE -> PREAMBLE -> SYMBOLS -> IDLE:
  - IDLE:
    - On num_symbols_valid with num_symbols in 1..MAX_NUM_SYMBOLS, latch num_symbols and go to PREAMBLE.
    - A value of 0 or one above the maximum is ignored.
    - num_symbols_valid is ignored outside IDLE.
  - PREAMBLE:
    - Outputs preamble RAM addresses 0..PREAMBLE_LEN-1 in order.
    - The address advances only on an o_tvalid&&o_tready handshake.
    - After the final preamble handshake, go to SYMBOLS.
  - SYMBOLS, per symbol k:
    - Wait until buffer k%2 is full; o_tvalid=0 while it is not (underflow bubble, never corrupt data).
    - Then read addresses SYMBOL_LEN-CYCLIC_PREFIX_LEN .. SYMBOL_LEN-1, followed by 0..SYMBOL_LEN-1.
    - The buffer is released (marked empty) on its final read handshake.
    - o_tlast=1 on the last sample of the last symbol; go to IDLE on that handshake.
- Input side:
  - Active from the latch until num_symbols*SYMBOL_LEN samples have been accepted; this overlaps PREAMBLE, so the first buffer fills during the preamble.
  - i_tready = active && write buffer not full.
  - Samples fill the write buffer at addresses 0..SYMBOL_LEN-1; after the last address the buffer is marked full and the write pointer toggles to the other buffer.
  - If a buffer is released and filled in the same cycle, both events are honoured.
- i_tlast check:
  - o_err pulses for one cycle if i_tlast=1 on any accepted sample other than the burst's last.
  - o_err also pulses if i_tlast=0 on the burst's last sample.
  - Framing is governed by counts only; i_tlast never changes the output.
- Output stage:
  - The RAMs read synchronously; a registered output plus a 2-entry skid buffer sustain one sample per cycle with o_tready held high.
  - o_tdata/o_tlast stay stable while o_tvalid=1 and o_tready=0.
- Latency: first o_tvalid occurs 2 cycles after the num_symbols_valid latch cycle.
- Burst length = PREAMBLE_LEN + num_symbols*(CYCLIC_PREFIX_LEN+SYMBOL_LEN); there are no gaps inside a burst when input keeps up.
- Back-to-back bursts: a new num_symbols_valid is accepted the cycle after the o_tlast handshake.

Test Plan:
- Load preamble with value = address. Strobe num_symbols=2 and feed ramp symbols 0..127, i_tlast on sample 127, o_tready=1 -> 480 samples out:
  - Preamble outputs 0..319.
  - Symbol 0 outputs 48..63, 0..63.
  - Symbol 1 outputs 112..127, 64..127.
  - o_tlast only on sample 480.
  - No o_valid gaps; o_err never pulses.
- Random o_tready (50%) and random i_tvalid (50%), num_symbols=5 -> output sequence identical to the stall-free case; 720 samples; data stable while stalled.
- Input delayed until the preamble has finished -> o_tvalid=0 until buffer 0 is full, then the correct cyclic prefix plus symbol.
- num_symbols=1, i_tlast placed on sample 10 -> o_err pulses once at that sample; output is still 400 samples with o_tlast at 400.
- Assert reset at output sample 350 of a num_symbols=3 burst, then start num_symbols=1 -> the new burst is the full preamble from RAM (contents retained) plus 80 samples; no stale symbol data appears.
- num_symbols_valid with num_symbols=0 -> remains IDLE; i_tready=0, o_tvalid=0. A pre_wr_stb during PREAMBLE does not alter the RAM.
